// File: rtl/multicycle_controller.sv
// ==== multicycle_controller : multicycle MIPS-subset control FSM (rev 1.0) ====
`default_nettype none

module multicycle_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       iord,
  output logic       alu_src_a,
  output logic [1:0] pc_src,
  output logic [1:0] reg_dst,
  output logic [1:0] wb_sel,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic       done,
  output logic       illegal,
  output logic [3:0] state
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEM_ADDR = 4'd2;
  localparam logic [3:0] S_MEM_RD   = 4'd3;
  localparam logic [3:0] S_MEM_WB   = 4'd4;
  localparam logic [3:0] S_MEM_WR   = 4'd5;
  localparam logic [3:0] S_R_EX     = 4'd6;
  localparam logic [3:0] S_R_WB     = 4'd7;
  localparam logic [3:0] S_BEQ      = 4'd8;
  localparam logic [3:0] S_JMP      = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_I_EX     = 4'd11;
  localparam logic [3:0] S_I_WB     = 4'd12;
  localparam logic [3:0] S_JR       = 4'd13;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  logic [3:0] state_q, state_d;
  logic       r_legal;
  logic [2:0] r_alu_op;
  logic [2:0] i_alu_op;

  always_comb begin
    r_legal  = 1'b1;
    r_alu_op = ALU_ADD;
    case (func)
      6'b100000: r_alu_op = ALU_ADD;
      6'b100010: r_alu_op = ALU_SUB;
      6'b100100: r_alu_op = ALU_AND;
      6'b100101: r_alu_op = ALU_OR;
      6'b101010: r_alu_op = ALU_SLT;
      default:   r_legal  = 1'b0;
    endcase
  end

  always_comb begin
    case (opcode)
      OP_SLTI: i_alu_op = ALU_SLT;
      OP_ANDI: i_alu_op = ALU_AND;
      default: i_alu_op = ALU_ADD;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_write  = 1'b0;
    ir_write  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    iord      = 1'b0;
    alu_src_a = 1'b0;
    pc_src    = 2'b00;
    reg_dst   = 2'b00;
    wb_sel    = 2'b00;
    alu_src_b = 2'b00;
    alu_op    = ALU_ADD;
    done      = 1'b0;
    illegal   = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_RTYPE:                  state_d = (func == FN_JR) ? S_JR : S_R_EX;
          OP_LW, OP_SW:              state_d = S_MEM_ADDR;
          OP_BEQ:                    state_d = S_BEQ;
          OP_J:                      state_d = S_JMP;
          OP_JAL:                    state_d = S_JAL;
          OP_ADDI, OP_SLTI, OP_ANDI: state_d = S_I_EX;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write = 1'b1;
        wb_sel    = 2'b01;
        done      = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        done      = mem_ready;
        if (mem_ready) state_d = S_FETCH;
      end
      S_R_EX: begin
        alu_src_a = 1'b1;
        alu_op    = r_alu_op;
        illegal   = ~r_legal;
        state_d   = r_legal ? S_R_WB : S_FETCH;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 2'b01;
        done      = 1'b1;
        state_d   = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_src    = 2'b01;
        pc_write  = zero;
        done      = 1'b1;
        state_d   = S_FETCH;
      end
      S_JMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
        done     = 1'b1;
        state_d  = S_FETCH;
      end
      S_JAL: begin
        // PC already holds PC+4 here, so the link value comes straight from PC
        pc_src    = 2'b10;
        pc_write  = 1'b1;
        reg_write = 1'b1;
        reg_dst   = 2'b10;
        wb_sel    = 2'b10;
        done      = 1'b1;
        state_d   = S_FETCH;
      end
      S_JR: begin
        pc_src   = 2'b11;
        pc_write = 1'b1;
        done     = 1'b1;
        state_d  = S_FETCH;
      end
      S_I_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = i_alu_op;
        state_d   = S_I_WB;
      end
      S_I_WB: begin
        reg_write = 1'b1;
        done      = 1'b1;
        state_d   = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // Reset presents FETCH datapath selects with every enable and pulse held low
    if (rst) begin
      state_d   = S_FETCH;
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
      done      = 1'b0;
      illegal   = 1'b0;
      iord      = 1'b0;
      alu_src_a = 1'b0;
      pc_src    = 2'b00;
      reg_dst   = 2'b00;
      wb_sel    = 2'b00;
      alu_src_b = 2'b01;
      alu_op    = ALU_ADD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  assign state = state_q;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_controller.sv
// ==== tb_multicycle_controller : directed-vector bench for multicycle_controller (rev 1.0) ====
`default_nettype none

module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode, func;
  logic       zero, mem_ready;
  logic       pc_write, ir_write, mem_read, mem_write, reg_write, iord, alu_src_a;
  logic [1:0] pc_src, reg_dst, wb_sel, alu_src_b;
  logic [2:0] alu_op;
  logic       done, illegal;
  logic [3:0] state;

  int vecs  = 0;
  int fails = 0;

  logic [23:0] obs;
  logic [23:0] E_FETCH, E_FSTALL, E_DECODE;

  multicycle_controller dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func(func), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .iord(iord), .alu_src_a(alu_src_a), .pc_src(pc_src),
    .reg_dst(reg_dst), .wb_sel(wb_sel), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .done(done), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  // en = {pc_write, ir_write, mem_read, mem_write, reg_write, iord, alu_src_a}
  assign obs = {state, pc_write, ir_write, mem_read, mem_write, reg_write, iord, alu_src_a,
                pc_src, reg_dst, wb_sel, alu_src_b, alu_op, done, illegal};

  function automatic logic [23:0] pk(input logic [3:0] st, input logic [6:0] en,
                                     input logic [1:0] pcs, input logic [1:0] rd,
                                     input logic [1:0] wb, input logic [1:0] asb,
                                     input logic [2:0] aop, input logic dn, input logic il);
    return {st, en, pcs, rd, wb, asb, aop, dn, il};
  endfunction

  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input logic mr, input logic r);
    opcode = op; func = fn; zero = z; mem_ready = mr; rst = r;
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [23:0] e;
    e = pk(4'd0, 7'b0000000, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      drive(6'b000000, 6'b000000, 1'b1, 1'b1, 1'b1);
      vecs++;
      if (obs !== e) begin fails++; $display("FAIL reset c%0d: got %h want %h", i, obs, e); end
      tick();
    end
  endtask

  task automatic test_lw();
    logic [23:0] e [5];
    e = '{E_FETCH, E_DECODE,
          pk(4'd2, 7'b0000001, 2'b00, 2'b00, 2'b00, 2'b10, 3'b000, 1'b0, 1'b0),
          pk(4'd3, 7'b0010010, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0),
          pk(4'd4, 7'b0000100, 2'b00, 2'b00, 2'b01, 2'b00, 3'b000, 1'b1, 1'b0)};
    for (int i = 0; i < 5; i++) begin
      drive(6'b100011, 6'b000000, 1'b0, 1'b1, 1'b0);
      vecs++;
      if (obs !== e[i]) begin fails++; $display("FAIL lw c%0d: got %h want %h", i + 1, obs, e[i]); end
      tick();
    end
  endtask

  task automatic test_sw_stall();
    logic [23:0] e [7];
    logic [6:0]  mr;
    mr = 7'b1000111;
    e = '{E_FETCH, E_DECODE,
          pk(4'd2, 7'b0000001, 2'b00, 2'b00, 2'b00, 2'b10, 3'b000, 1'b0, 1'b0),
          pk(4'd5, 7'b0001010, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0),
          pk(4'd5, 7'b0001010, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0),
          pk(4'd5, 7'b0001010, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0),
          pk(4'd5, 7'b0001010, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1, 1'b0)};
    for (int i = 0; i < 7; i++) begin
      drive(6'b101011, 6'b000000, 1'b0, mr[i], 1'b0);
      vecs++;
      if (obs !== e[i]) begin fails++; $display("FAIL sw_stall c%0d: got %h want %h", i + 1, obs, e[i]); end
      tick();
    end
  endtask

  task automatic test_beq(input logic z);
    logic [23:0] e [3];
    e = '{E_FETCH, E_DECODE,
          pk(4'd8, {z, 6'b000001}, 2'b01, 2'b00, 2'b00, 2'b00, 3'b001, 1'b1, 1'b0)};
    for (int i = 0; i < 3; i++) begin
      drive(6'b000100, 6'b000000, z, 1'b1, 1'b0);
      vecs++;
      if (obs !== e[i]) begin fails++; $display("FAIL beq z=%0d c%0d: got %h want %h", z, i + 1, obs, e[i]); end
      tick();
    end
  endtask

  task automatic test_jumps();
    logic [23:0] e [3][3];
    logic [5:0]  op [3];
    logic [5:0]  fn [3];
    op = '{6'b000011, 6'b000010, 6'b000000};
    fn = '{6'b000000, 6'b000000, 6'b001000};
    e[0] = '{E_FETCH, E_DECODE, pk(4'd10, 7'b1000100, 2'b10, 2'b10, 2'b10, 2'b00, 3'b000, 1'b1, 1'b0)};
    e[1] = '{E_FETCH, E_DECODE, pk(4'd9,  7'b1000000, 2'b10, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1, 1'b0)};
    e[2] = '{E_FETCH, E_DECODE, pk(4'd13, 7'b1000000, 2'b11, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1, 1'b0)};
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 3; i++) begin
        drive(op[k], fn[k], 1'b0, 1'b1, 1'b0);
        vecs++;
        if (obs !== e[k][i]) begin
          fails++; $display("FAIL jump op=%b c%0d: got %h want %h", op[k], i + 1, obs, e[k][i]);
        end
        tick();
      end
    end
  endtask

  task automatic test_fetch_stall_jr();
    drive(6'b000000, 6'b001000, 1'b0, 1'b0, 1'b0);
    vecs++;
    if (obs !== E_FSTALL) begin fails++; $display("FAIL fetch_stall: got %h want %h", obs, E_FSTALL); end
    tick();
    test_jumps();
  endtask

  task automatic test_illegal_opcode();
    logic [23:0] e [3];
    logic [2:0]  mr;
    mr = 3'b011;
    e = '{E_FETCH, pk(4'd1, 7'b0000000, 2'b00, 2'b00, 2'b00, 2'b11, 3'b000, 1'b0, 1'b1), E_FSTALL};
    for (int i = 0; i < 3; i++) begin
      drive(6'b111111, 6'b000000, 1'b0, mr[i], 1'b0);
      vecs++;
      if (obs !== e[i]) begin fails++; $display("FAIL illegal_op c%0d: got %h want %h", i + 1, obs, e[i]); end
      tick();
    end
  endtask

  task automatic test_rtype();
    logic [23:0] e [4];
    logic [5:0]  fn [3];
    logic [2:0]  aop [3];
    fn  = '{6'b100010, 6'b100101, 6'b101010};
    aop = '{3'b001, 3'b011, 3'b100};
    for (int k = 0; k < 3; k++) begin
      e = '{E_FETCH, E_DECODE,
            pk(4'd6, 7'b0000001, 2'b00, 2'b00, 2'b00, 2'b00, aop[k], 1'b0, 1'b0),
            pk(4'd7, 7'b0000100, 2'b00, 2'b01, 2'b00, 2'b00, 3'b000, 1'b1, 1'b0)};
      for (int i = 0; i < 4; i++) begin
        drive(6'b000000, fn[k], 1'b0, 1'b1, 1'b0);
        vecs++;
        if (obs !== e[i]) begin fails++; $display("FAIL rtype fn=%b c%0d: got %h want %h", fn[k], i + 1, obs, e[i]); end
        tick();
      end
    end
    e = '{E_FETCH, E_DECODE,
          pk(4'd6, 7'b0000001, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b1), E_FETCH};
    for (int i = 0; i < 4; i++) begin
      drive(6'b000000, 6'b000111, 1'b0, 1'b1, 1'b0);
      vecs++;
      if (obs !== e[i]) begin fails++; $display("FAIL rtype_illegal c%0d: got %h want %h", i + 1, obs, e[i]); end
      tick();
    end
    // the trailing FETCH advanced into DECODE; drain it through the illegal path once more
    drive(6'b000000, 6'b000111, 1'b0, 1'b1, 1'b0);
    vecs++;
    if (obs !== E_DECODE) begin fails++; $display("FAIL rtype_drain: got %h want %h", obs, E_DECODE); end
    tick();
    drive(6'b000000, 6'b000111, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_itype();
    logic [23:0] e [4];
    logic [5:0]  op [3];
    logic [2:0]  aop [3];
    op  = '{6'b001000, 6'b001010, 6'b001100};
    aop = '{3'b000, 3'b100, 3'b010};
    for (int k = 0; k < 3; k++) begin
      e = '{E_FETCH, E_DECODE,
            pk(4'd11, 7'b0000001, 2'b00, 2'b00, 2'b00, 2'b10, aop[k], 1'b0, 1'b0),
            pk(4'd12, 7'b0000100, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1, 1'b0)};
      for (int i = 0; i < 4; i++) begin
        drive(op[k], 6'b000000, 1'b0, 1'b1, 1'b0);
        vecs++;
        if (obs !== e[i]) begin fails++; $display("FAIL itype op=%b c%0d: got %h want %h", op[k], i + 1, obs, e[i]); end
        tick();
      end
    end
  endtask

  task automatic test_reset_midstall();
    logic [23:0] e [10];
    logic [9:0]  mr, rs;
    mr = 10'b1111100111;
    rs = 10'b0000010000;
    e = '{E_FETCH, E_DECODE,
          pk(4'd2, 7'b0000001, 2'b00, 2'b00, 2'b00, 2'b10, 3'b000, 1'b0, 1'b0),
          pk(4'd3, 7'b0010010, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0),
          pk(4'd3, 7'b0000000, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 1'b0, 1'b0),
          E_FETCH, E_DECODE,
          pk(4'd2, 7'b0000001, 2'b00, 2'b00, 2'b00, 2'b10, 3'b000, 1'b0, 1'b0),
          pk(4'd3, 7'b0010010, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0),
          pk(4'd4, 7'b0000100, 2'b00, 2'b00, 2'b01, 2'b00, 3'b000, 1'b1, 1'b0)};
    for (int i = 0; i < 10; i++) begin
      drive(6'b100011, 6'b000000, 1'b0, mr[i], rs[i]);
      vecs++;
      if (obs !== e[i]) begin fails++; $display("FAIL reset_midstall c%0d: got %h want %h", i + 1, obs, e[i]); end
      tick();
    end
  endtask

  initial begin
    E_FETCH  = pk(4'd0, 7'b1110000, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 1'b0, 1'b0);
    E_FSTALL = pk(4'd0, 7'b0010000, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 1'b0, 1'b0);
    E_DECODE = pk(4'd1, 7'b0000000, 2'b00, 2'b00, 2'b00, 2'b11, 3'b000, 1'b0, 1'b0);
    rst = 1'b1; opcode = 6'd0; func = 6'd0; zero = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_lw();
    test_sw_stall();
    test_beq(1'b1);
    test_beq(1'b0);
    test_fetch_stall_jr();
    test_illegal_opcode();
    test_rtype();
    test_itype();
    test_reset_midstall();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have port clk, input, 1, sole clock, rising-edge.
REQ-002 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-003 SHALL have port opcode, input, 6, instruction bits [31:26] from the instruction register.
REQ-004 SHALL have port func, input, 6, instruction bits [5:0].
REQ-005 SHALL have port zero, input, 1, ALU zero flag.
REQ-006 SHALL have port mem_ready, input, 1, memory access complete this cycle.
REQ-007 SHALL have ports pc_write, ir_write, mem_read, mem_write, reg_write, iord, alu_src_a, each output, 1.
REQ-008 SHALL have ports pc_src, reg_dst, wb_sel, alu_src_b, each output, 2.
  - pc_src: 00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = rs.
  - reg_dst: 00 = rt, 01 = rd, 10 = r31.
  - wb_sel: 00 = ALUOut, 01 = MDR, 10 = PC.
  - alu_src_b: 00 = rt, 01 = 4, 10 = sext, 11 = sext<<2.
REQ-009 SHALL have port alu_op, output, 3.
  - Encoding: 000 add, 001 sub, 010 and, 011 or, 100 slt.
REQ-010 SHALL have ports done and illegal, each output, 1, single-cycle pulses.
REQ-011 SHALL have port state, output, 4, current state code, for debug.

Function
REQ-012 SHALL implement the states below.
  - FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5.
  - R_EX=6, R_WB=7, BEQ=8, JMP=9, JAL=10, I_EX=11, I_WB=12, JR=13.
  - All other codes are unused.
REQ-013 SHALL default every output to 0 in every state unless this document lists it for that state.
REQ-014 In FETCH the block SHALL drive mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=add, pc_src=00.
  - ir_write=1 and pc_write=1 only in a cycle with mem_ready=1.
  - Remain in FETCH while mem_ready=0.
  - Go to DECODE on mem_ready=1.
REQ-015 In DECODE the block SHALL drive alu_src_a=0, alu_src_b=11, alu_op=add, and dispatch on opcode.
  - 000000 with func 001000 -> JR.
  - 000000 with any other func -> R_EX.
  - 100011 (lw) and 101011 (sw) -> MEM_ADDR.
  - 000100 (beq) -> BEQ.
  - 000010 (j) -> JMP.
  - 000011 (jal) -> JAL.
  - 001000 (addi), 001010 (slti), 001100 (andi) -> I_EX.
  - Any other opcode -> FETCH, with illegal=1 for that cycle.
REQ-016 MEM_ADDR SHALL drive alu_src_a=1, alu_src_b=10, alu_op=add.
  - Next state is MEM_RD for lw, MEM_WR for sw.
REQ-017 MEM_RD SHALL drive mem_read=1, iord=1.
  - Hold while mem_ready=0.
  - Go to MEM_WB on mem_ready=1.
REQ-018 MEM_WB SHALL drive reg_write=1, reg_dst=00, wb_sel=01, done=1.
  - Next state is FETCH.
REQ-019 MEM_WR SHALL drive mem_write=1, iord=1.
  - Hold while mem_ready=0.
  - On mem_ready=1, assert done=1 and go to FETCH.
REQ-020 R_EX SHALL drive alu_src_a=1, alu_src_b=00, with alu_op from func.
  - 100000 -> add; 100010 -> sub; 100100 -> and; 100101 -> or; 101010 -> slt.
  - Any other func: illegal=1, next state FETCH, no write-back.
  - Otherwise next state is R_WB.
REQ-021 R_WB SHALL drive reg_write=1, reg_dst=01, wb_sel=00, done=1.
  - Next state is FETCH.
REQ-022 BEQ SHALL drive alu_src_a=1, alu_src_b=00, alu_op=sub, pc_src=01, done=1.
  - pc_write equals zero (combinational).
  - Next state is FETCH.
REQ-023 JMP SHALL drive pc_src=10, pc_write=1, done=1.
  - Next state is FETCH.
REQ-024 JAL SHALL drive pc_src=10, pc_write=1, reg_write=1, reg_dst=10, wb_sel=10, done=1.
  - Next state is FETCH.
  - Register write SHALL use the already-incremented PC, i.e. PC+4 of the jal.
REQ-025 JR SHALL drive pc_src=11, pc_write=1, done=1.
  - Next state is FETCH.
REQ-026 I_EX SHALL drive alu_src_a=1, alu_src_b=10.
  - alu_op: add for addi, slt for slti, and for andi.
  - Next state is I_WB.
REQ-027 I_WB SHALL drive reg_write=1, reg_dst=00, wb_sel=00, done=1.
  - Next state is FETCH.
REQ-028 SHALL have a total latency, in cycles with mem_ready held at 1, as follows.
  - lw 5; sw 4; R-type 4; addi/slti/andi 4; beq, j, jal, jr 3.
REQ-029 SHALL extend the latency by one cycle for each mem_ready=0 cycle spent in FETCH, MEM_RD or MEM_WR.
REQ-030 SHALL keep state, opcode and func sampling unaffected by mem_ready in all states except FETCH, MEM_RD and MEM_WR.
REQ-031 SHALL go to FETCH on the next edge if it ever reaches an unused state code, with all outputs 0 while in that code.

Reset
REQ-032 SHALL load state=FETCH on any rising clk edge where rst=1.
  - This applies regardless of current state, including a stall mid-operation.
REQ-033 SHALL force pc_write, ir_write, mem_read, mem_write, reg_write, done and illegal to 0 while rst=1.
  - All other outputs SHALL take their FETCH values during reset.
REQ-034 SHALL begin FETCH normally on the first edge after rst is deasserted.

Verification
REQ-035 SHALL show lw: opcode=100011, mem_ready=1 -> states 0,1,2,3,4.
  - reg_write=1 only in cycle 5, with wb_sel=01; done in cycle 5.
REQ-036 SHALL show beq taken vs not taken: opcode=000100.
  - zero=1 -> pc_write=1 in cycle 3 with pc_src=01.
  - zero=0 -> pc_write=0.
  - Both return to state 0.
REQ-037 SHALL show sw with mem_ready low for 3 cycles in MEM_WR.
  - mem_write held for 4 cycles; done pulses once; 7 cycles total.
REQ-038 SHALL show illegal decode.
  - opcode=111111 -> illegal=1 in cycle 2, then state 0, no reg_write.
  - R-type with func=000111 -> illegal in R_EX.
REQ-039 SHALL show jal: opcode=000011 -> in cycle 3, pc_write=1, reg_write=1, reg_dst=10, wb_sel=10.
REQ-040 SHALL show reset during a MEM_RD stall.
  - rst=1 for one edge -> state=0 and all enables 0 that cycle.
  - The next fetch proceeds normally.
